// File: rtl/pzcorebus_csrbus_request_scheduler.sv
// pzcorebus_csrbus_request_scheduler
//   Round-robin scheduler that funnels N requester CSR command ports onto a
//   single master command port and routes master responses back by ID.
//   Non-posted commands (reads and non-posted writes) are tracked per
//   requester and throttled at MAX_OUTSTANDING; posted commands are never
//   throttled.
//
// Ports
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_mcmd_valid/i_mcmd/i_maddr/i_mdata   per-requester command inputs
//   o_scmd_accept                per-requester command accept
//   o_sresp_valid/o_serror/o_sdata        per-requester response outputs
//   i_mresp_accept               per-requester response accept
//   o_mcmd_valid/i_scmd_accept/o_mcmd/o_mid/o_maddr/o_mdata  master command
//   i_sresp_valid/o_mresp_accept/i_sid/i_serror/i_sdata      master response
//   o_idle                       no non-posted command outstanding
//   o_protocol_error             sticky: response with unknown/idle ID seen
module pzcorebus_csrbus_request_scheduler #(
  parameter int N_REQUESTERS    = 4,
  parameter int ID_WIDTH        = 8,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [N_REQUESTERS-1:0]                  i_mcmd_valid,
  input  logic [N_REQUESTERS-1:0][1:0]             i_mcmd,
  input  logic [N_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] i_maddr,
  input  logic [N_REQUESTERS-1:0][DATA_WIDTH-1:0]  i_mdata,
  output logic [N_REQUESTERS-1:0]                  o_scmd_accept,
  output logic [N_REQUESTERS-1:0]                  o_sresp_valid,
  output logic [N_REQUESTERS-1:0]                  o_serror,
  output logic [N_REQUESTERS-1:0][DATA_WIDTH-1:0]  o_sdata,
  input  logic [N_REQUESTERS-1:0]                  i_mresp_accept,
  output logic                                     o_mcmd_valid,
  input  logic                                     i_scmd_accept,
  output logic [1:0]                               o_mcmd,
  output logic [ID_WIDTH-1:0]                      o_mid,
  output logic [ADDRESS_WIDTH-1:0]                 o_maddr,
  output logic [DATA_WIDTH-1:0]                    o_mdata,
  input  logic                                     i_sresp_valid,
  output logic                                     o_mresp_accept,
  input  logic [ID_WIDTH-1:0]                      i_sid,
  input  logic                                     i_serror,
  input  logic [DATA_WIDTH-1:0]                    i_sdata,
  output logic                                     o_idle,
  output logic                                     o_protocol_error
);

  localparam int IDX_W = $clog2(N_REQUESTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_ARB, ST_LOCK} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   lock_idx;
  logic [CNT_W-1:0]   outstanding [N_REQUESTERS];
  logic               protocol_error;

  logic [N_REQUESTERS-1:0] eligible;
  logic [N_REQUESTERS-1:0] nz;
  logic [N_REQUESTERS-1:0] sid_hit;
  logic [N_REQUESTERS-1:0] inc;
  logic [N_REQUESTERS-1:0] dec;
  logic                    hi_found, lo_found, gnt_found;
  logic [IDX_W-1:0]        hi_idx, lo_idx, gnt_idx;
  logic                    sel_valid;
  logic                    ack;
  logic                    sid_ok;
  logic                    resp_err;

  // Posted commands (type 2 and reserved type 3) share bit 1 set.
  always_comb begin
    for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
      nz[k]       = (outstanding[k] != '0);
      eligible[k] = i_mcmd_valid[k] && (i_mcmd[k][1] || (outstanding[k] < CNT_MAX));
    end
  end

  // Round-robin: first eligible at or above the pointer, otherwise the first
  // eligible from index 0 (the wrapped part of the search).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
      if (eligible[k] && (IDX_W'(k) >= ptr) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(k);
      end
      if (eligible[k] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(k);
      end
    end
    if (state == ST_LOCK) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_idx;
    end else begin
      gnt_found = hi_found || lo_found;
      gnt_idx   = hi_found ? hi_idx : lo_idx;
    end
  end

  // Command mux towards the master port.
  always_comb begin
    sel_valid     = 1'b0;
    o_mcmd        = '0;
    o_maddr       = '0;
    o_mdata       = '0;
    o_scmd_accept = '0;
    for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        sel_valid        = i_mcmd_valid[k];
        o_mcmd           = i_mcmd[k];
        o_maddr          = i_maddr[k];
        o_mdata          = i_mdata[k];
        o_scmd_accept[k] = gnt_found && i_scmd_accept;
      end
    end
    o_mcmd_valid = gnt_found && sel_valid;
    o_mid        = ID_WIDTH'(gnt_idx);
    ack          = o_mcmd_valid && i_scmd_accept;
    for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
      inc[k] = ack && (gnt_idx == IDX_W'(k)) && !o_mcmd[1];
    end
  end

  // Response routing; an ID that is out of range or has nothing outstanding
  // is swallowed (accepted, routed nowhere) and flagged.
  always_comb begin
    o_sresp_valid  = '0;
    o_serror       = '0;
    o_sdata        = '0;
    o_mresp_accept = 1'b1;
    sid_ok         = 1'b0;
    dec            = '0;
    for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
      sid_hit[k] = (i_sid == ID_WIDTH'(k));
      if (sid_hit[k] && nz[k]) begin
        sid_ok           = 1'b1;
        o_sresp_valid[k] = i_sresp_valid;
        o_serror[k]      = i_serror;
        o_sdata[k]       = i_sdata;
        o_mresp_accept   = i_mresp_accept[k];
        dec[k]           = i_sresp_valid && i_mresp_accept[k];
      end
    end
    resp_err = i_sresp_valid && !sid_ok;
  end

  always_comb begin
    o_idle = ~|nz;
  end

  assign o_protocol_error = protocol_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_ARB;
      ptr            <= '0;
      lock_idx       <= '0;
      protocol_error <= 1'b0;
      for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
        outstanding[k] <= '0;
      end
    end else begin
      state    <= (o_mcmd_valid && !i_scmd_accept) ? ST_LOCK : ST_ARB;
      lock_idx <= gnt_idx;
      if (ack) begin
        ptr <= (gnt_idx == IDX_W'(N_REQUESTERS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (resp_err) begin
        protocol_error <= 1'b1;
      end
      for (int unsigned k = 0; k < N_REQUESTERS; k++) begin
        if (inc[k] && !dec[k]) begin
          outstanding[k] <= outstanding[k] + 1'b1;
        end else if (dec[k] && !inc[k]) begin
          outstanding[k] <= outstanding[k] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pzcorebus_csrbus_request_scheduler.sv
module tb_pzcorebus_csrbus_request_scheduler;

  logic              clk;
  logic              rst_n;
  logic [3:0]        mcmd_valid;
  logic [3:0][1:0]   mcmd;
  logic [3:0][15:0]  maddr;
  logic [3:0][31:0]  mdata;
  logic [3:0]        o_scmd_accept;
  logic [3:0]        o_sresp_valid;
  logic [3:0]        o_serror;
  logic [3:0][31:0]  o_sdata;
  logic [3:0]        mresp_accept;
  logic              o_mcmd_valid;
  logic              scmd_accept;
  logic [1:0]        o_mcmd;
  logic [7:0]        o_mid;
  logic [15:0]       o_maddr;
  logic [31:0]       o_mdata;
  logic              sresp_valid;
  logic              o_mresp_accept;
  logic [7:0]        sid;
  logic              serror;
  logic [31:0]       sdata;
  logic              o_idle;
  logic              o_protocol_error;

  int tests;
  int fails;

  pzcorebus_csrbus_request_scheduler #(
    .N_REQUESTERS(4), .ID_WIDTH(8), .ADDRESS_WIDTH(16),
    .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mcmd_valid(mcmd_valid), .i_mcmd(mcmd), .i_maddr(maddr), .i_mdata(mdata),
    .o_scmd_accept(o_scmd_accept),
    .o_sresp_valid(o_sresp_valid), .o_serror(o_serror), .o_sdata(o_sdata),
    .i_mresp_accept(mresp_accept),
    .o_mcmd_valid(o_mcmd_valid), .i_scmd_accept(scmd_accept), .o_mcmd(o_mcmd),
    .o_mid(o_mid), .o_maddr(o_maddr), .o_mdata(o_mdata),
    .i_sresp_valid(sresp_valid), .o_mresp_accept(o_mresp_accept), .i_sid(sid),
    .i_serror(serror), .i_sdata(sdata),
    .o_idle(o_idle), .o_protocol_error(o_protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the
  // falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mcmd_valid   = '0;
    mcmd         = '0;
    scmd_accept  = 1'b0;
    sresp_valid  = 1'b0;
    mresp_accept = '0;
    sid          = '0;
    serror       = 1'b0;
    sdata        = '0;
  endtask

  // One accepted response for requester k; checks routing on the way.
  task automatic respond(input int k, input string tag);
    sresp_valid  = 1'b1;
    sid          = 8'(k);
    sdata        = 32'h5000 + 32'(k);
    serror       = k[0];
    mresp_accept = 4'hF;
    @(negedge clk);
    check({tag, "_svalid"}, o_sresp_valid, 64'(1) << k);
    check({tag, "_macc"}, o_mresp_accept, 1);
    check({tag, "_sdata"}, o_sdata[k], 32'h5000 + k);
    check({tag, "_serr"}, o_serror, 64'(k % 2) << k);
    cyc();
    sresp_valid  = 1'b0;
    mresp_accept = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      maddr[k] = 16'h100 + 16'(k);
      mdata[k] = 32'hA0 + 32'(k);
    end

    // Reset state
    #2;
    check("rst_idle", o_idle, 1);
    check("rst_mvalid", o_mcmd_valid, 0);
    check("rst_sacc", o_scmd_accept, 0);
    check("rst_perr", o_protocol_error, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // All four requesters issue reads; grants in order 0..3
    mcmd_valid  = 4'hF;
    scmd_accept = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr_valid", o_mcmd_valid, 1);
      check("rr_mid", o_mid, 64'(c));
      check("rr_addr", o_maddr, 64'(16'h100 + c));
      check("rr_data", o_mdata, 64'(32'hA0 + c));
      check("rr_sacc", o_scmd_accept, 64'(1) << c);
      cyc();
      mcmd_valid[c] = 1'b0;
    end
    scmd_accept = 1'b0;
    @(negedge clk);
    check("rr_idle", o_idle, 0);
    check("rr_mvalid_off", o_mcmd_valid, 0);
    cyc();
    // exactly one outstanding each: one response per ID returns to idle
    for (int k = 0; k < 4; k++) respond(k, "rr_resp");
    @(negedge clk);
    check("rr_idle_back", o_idle, 1);
    check("rr_perr", o_protocol_error, 0);
    cyc();

    // Lock: requester 2 stalled while requester 0 also requests
    mcmd_valid = 4'b0100;
    mcmd[2]    = 2'd1;
    maddr[2]   = 16'h0222;
    mdata[2]   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("lk_mid0", o_mid, 2);
    check("lk_sacc0", o_scmd_accept, 0);
    cyc();
    mcmd_valid[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("lk_mid", o_mid, 2);
      check("lk_addr", o_maddr, 16'h0222);
      check("lk_data", o_mdata, 32'hDEAD_BEEF);
      check("lk_cmd", o_mcmd, 1);
      cyc();
    end
    scmd_accept = 1'b1;
    @(negedge clk);
    check("lk_acc_mid", o_mid, 2);
    check("lk_acc_sacc", o_scmd_accept, 4'b0100);
    cyc();
    mcmd_valid = 4'b1001;
    @(negedge clk);
    check("lk_next3", o_mid, 3);
    cyc();
    mcmd_valid = 4'b0001;
    @(negedge clk);
    check("lk_next0", o_mid, 0);
    check("lk_next0_sacc", o_scmd_accept, 4'b0001);
    cyc();
    clear_inputs();
    respond(0, "lk_r0");
    respond(2, "lk_r2");
    respond(3, "lk_r3");
    @(negedge clk);
    check("lk_idle", o_idle, 1);
    cyc();

    // Outstanding limit on requester 1
    mcmd_valid  = 4'b0010;
    mcmd[1]     = 2'd0;
    scmd_accept = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("lim_sacc", o_scmd_accept, 4'b0010);
      cyc();
    end
    @(negedge clk);
    check("lim_5th_valid", o_mcmd_valid, 0);
    check("lim_5th_sacc", o_scmd_accept, 0);
    cyc();
    mcmd[1] = 2'd2;
    @(negedge clk);
    check("lim_post_valid", o_mcmd_valid, 1);
    check("lim_post_cmd", o_mcmd, 2);
    check("lim_post_sacc", o_scmd_accept, 4'b0010);
    cyc();
    mcmd[1] = 2'd0;
    @(negedge clk);
    check("lim_still_blocked", o_mcmd_valid, 0);
    cyc();

    // Response back-pressure on requester 1 (read still pending, no master accept)
    scmd_accept  = 1'b0;
    sresp_valid  = 1'b1;
    sid          = 8'd1;
    sdata        = 32'h1234_5678;
    mresp_accept = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bp_svalid", o_sresp_valid, 4'b0010);
      check("bp_macc", o_mresp_accept, 0);
      check("bp_sdata", o_sdata[1], 32'h1234_5678);
      check("bp_blocked", o_mcmd_valid, 0);
      cyc();
    end
    mresp_accept = 4'b0010;
    @(negedge clk);
    check("bp_macc_on", o_mresp_accept, 1);
    cyc();
    sresp_valid  = 1'b0;
    mresp_accept = '0;
    @(negedge clk);
    check("bp_after_dec", o_mcmd_valid, 1);
    cyc();
    clear_inputs();
    respond(1, "bp_d1");
    respond(1, "bp_d2");
    @(negedge clk);
    check("bp_not_idle", o_idle, 0);
    cyc();
    respond(1, "bp_d3");
    @(negedge clk);
    check("bp_idle", o_idle, 1);
    check("bp_perr", o_protocol_error, 0);
    cyc();

    // Simultaneous non-posted ack and response on requester 2
    mcmd_valid  = 4'b0100;
    mcmd[2]     = 2'd0;
    scmd_accept = 1'b1;
    cyc();
    sresp_valid  = 1'b1;
    sid          = 8'd2;
    mresp_accept = 4'b0100;
    @(negedge clk);
    check("sim_sacc", o_scmd_accept, 4'b0100);
    check("sim_svalid", o_sresp_valid, 4'b0100);
    cyc();
    clear_inputs();
    @(negedge clk);
    check("sim_not_idle", o_idle, 0);
    cyc();
    respond(2, "sim_r2");
    @(negedge clk);
    check("sim_idle", o_idle, 1);
    check("sim_perr", o_protocol_error, 0);
    cyc();

    // Out-of-range response ID
    sresp_valid  = 1'b1;
    sid          = 8'd7;
    mresp_accept = '0;
    @(negedge clk);
    check("bad_macc", o_mresp_accept, 1);
    check("bad_svalid", o_sresp_valid, 0);
    check("bad_perr_pre", o_protocol_error, 0);
    cyc();
    sresp_valid = 1'b0;
    @(negedge clk);
    check("bad_perr", o_protocol_error, 1);
    cyc();
    cyc();
    @(negedge clk);
    check("bad_perr_sticky", o_protocol_error, 1);

    // Reset mid-transaction
    cyc();
    mcmd_valid  = 4'b0001;
    mcmd[0]     = 2'd0;
    scmd_accept = 1'b1;
    cyc();
    clear_inputs();
    @(negedge clk);
    check("mr_not_idle", o_idle, 0);
    rst_n = 1'b0;
    #1;
    check("mr_idle", o_idle, 1);
    check("mr_perr", o_protocol_error, 0);
    check("mr_sacc", o_scmd_accept, 0);
    check("mr_mvalid", o_mcmd_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    sresp_valid  = 1'b1;
    sid          = 8'd0;
    mresp_accept = '0;
    @(negedge clk);
    check("pr_macc", o_mresp_accept, 1);
    check("pr_svalid", o_sresp_valid, 0);
    cyc();
    sresp_valid = 1'b0;
    @(negedge clk);
    check("pr_perr", o_protocol_error, 1);
    check("pr_idle", o_idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
